// File: rtl/blake2_msg_sched.sv
// BLAKE2 message-word scheduler: captures one 16-word block and streams the
// (x, y) message-word pairs for each G call over all rounds, in SIGMA order.
// Optional build macro BLAKE2_SCHED_PAR4_EN: each beat carries a half-round
// (four G pairs) on 4*W-wide x_o/y_o, and g_idx_o steps 0, 4.
module blake2_msg_sched #(
    parameter int unsigned W = 64,
    parameter int unsigned R = 12,
`ifdef BLAKE2_SCHED_PAR4_EN
    localparam int unsigned Lanes = 4
`else
    localparam int unsigned Lanes = 1
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m_valid_i,
    output logic                 m_ready_o,
    input  logic [16*W-1:0]      m_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [Lanes*W-1:0]   x_o,
    output logic [Lanes*W-1:0]   y_o,
    output logic [2:0]           g_idx_o,
    output logic [3:0]           round_o,
    output logic                 last_o
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    localparam logic [2:0] GStep = 3'(Lanes);
    localparam logic [2:0] GLast = 3'(8 - Lanes);
    localparam logic [3:0] RLast = 4'(R - 1);

    logic [0:0]   state_q;
    logic [3:0]   round_q;
    logic [2:0]   g_q;
    logic [W-1:0] store_q [16];

    logic         run;
    logic         accept;
    logic         last;
    logic [3:0]   row_sel;
    logic [63:0]  row;
    logic [2:0]   lane_g;
    logic [3:0]   xi;
    logic [3:0]   yi;

    // SIGMA ROM: entry i of a row lives in nibble i (entry 0 is the LSB nibble).
    function automatic logic [63:0] sigma_row(input logic [3:0] r);
        unique case (r)
            4'd0:    sigma_row = 64'hFEDCBA9876543210;
            4'd1:    sigma_row = 64'h357B20C16DF984AE;
            4'd2:    sigma_row = 64'h491763EADF250C8B;
            4'd3:    sigma_row = 64'h8F04A562EBCD1397;
            4'd4:    sigma_row = 64'hD386CB1EFA427509;
            4'd5:    sigma_row = 64'h91EF57D438B0A6C2;
            4'd6:    sigma_row = 64'hB8293670A4DEF15C;
            4'd7:    sigma_row = 64'hA2684F05931CE7BD;
            4'd8:    sigma_row = 64'h5A417D2C803B9EF6;
            4'd9:    sigma_row = 64'h0DC3E9BF5167482A;
            default: sigma_row = 64'hFEDCBA9876543210;
        endcase
    endfunction

    assign run       = (state_q == StRun);
    assign accept    = !run && m_valid_i;
    assign last      = run && (round_q == RLast) && (g_q == GLast);

    assign m_ready_o = !run;
    assign valid_o   = run;
    assign last_o    = last;
    assign g_idx_o   = run ? g_q : 3'd0;
    assign round_o   = run ? round_q : 4'd0;

    // Rounds 10..14 reuse SIGMA rows 0..4.
    assign row_sel   = (round_q >= 4'd10) ? (round_q - 4'd10) : round_q;
    assign row       = sigma_row(row_sel);

    // Control: accept in IDLE, step g/round on each transfer, return to IDLE after the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            round_q <= 4'd0;
            g_q     <= 3'd0;
        end else if (!run) begin
            if (m_valid_i) begin
                state_q <= StRun;
                round_q <= 4'd0;
                g_q     <= 3'd0;
            end
        end else if (ready_i) begin
            if (last) begin
                state_q <= StIdle;
                round_q <= 4'd0;
                g_q     <= 3'd0;
            end else begin
                g_q <= g_q + GStep;
                if (g_q == GLast) begin
                    round_q <= round_q + 4'd1;
                end
            end
        end
    end

    // Block store: loaded only on acceptance, contents otherwise irrelevant.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 16; k++) begin
                store_q[k] <= m_i[k*W +: W];
            end
        end
    end

    // Pair selection per lane; outputs forced to zero while not valid.
    always_comb begin
        x_o    = '0;
        y_o    = '0;
        lane_g = 3'd0;
        xi     = 4'd0;
        yi     = 4'd0;
        for (int j = 0; j < int'(Lanes); j++) begin
            lane_g = g_q + 3'(j);
            xi     = row[{lane_g, 1'b0, 2'b00} +: 4];
            yi     = row[{lane_g, 1'b1, 2'b00} +: 4];
            if (run) begin
                x_o[j*W +: W] = store_q[xi];
                y_o[j*W +: W] = store_q[yi];
            end
        end
    end

endmodule

// File: tb/tb_blake2_msg_sched.sv
// Directed bench for blake2_msg_sched; follows BLAKE2_SCHED_PAR4_EN when defined.
module tb_blake2_msg_sched;

    localparam int W = 64;
`ifdef BLAKE2_SCHED_PAR4_EN
    localparam int R       = 10;
    localparam int LANES   = 4;
    localparam int STALL_G = 4;
    localparam int ABORT_G = 4;
`else
    localparam int R       = 12;
    localparam int LANES   = 1;
    localparam int STALL_G = 3;
    localparam int ABORT_G = 2;
`endif
    localparam int GSTEP = LANES;
    localparam int GLAST = 8 - LANES;

    localparam int SIGMA [10][16] = '{
        '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
        '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
        '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
        '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
        '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
        '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
        '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
        '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
        '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
        '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}
    };

    logic                 clk;
    logic                 rst;
    logic                 m_valid;
    logic                 m_ready;
    logic [16*W-1:0]      m;
    logic                 valid;
    logic                 ready;
    logic [LANES*W-1:0]   x;
    logic [LANES*W-1:0]   y;
    logic [2:0]           g_idx;
    logic [3:0]           round;
    logic                 last;

    int n_checks;
    int n_fail;

    blake2_msg_sched #(
        .W(W),
        .R(R)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m_valid_i (m_valid),
        .m_ready_o (m_ready),
        .m_i       (m),
        .valid_o   (valid),
        .ready_i   (ready),
        .x_o       (x),
        .y_o       (y),
        .g_idx_o   (g_idx),
        .round_o   (round),
        .last_o    (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] exp_word(input int r, input int g, input int base,
                                              input int sel_y);
        logic [255:0] v;
        v = '0;
        for (int j = 0; j < LANES; j++) begin
            v[j*W +: W] = W'(base + SIGMA[r % 10][2*(g + j) + sel_y]);
        end
        return v;
    endfunction

    function automatic logic [255:0] pack4(input int l0, input int l1, input int l2, input int l3);
        logic [255:0] v;
        v = '0;
        v[0*W +: W] = W'(l0);
        v[1*W +: W] = W'(l1);
        v[2*W +: W] = W'(l2);
        v[3*W +: W] = W'(l3);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " m_ready"}, 256'(m_ready), 256'(1));
        check({tag, " valid"}, 256'(valid), 256'(0));
        check({tag, " x"}, 256'(x), 256'(0));
        check({tag, " y"}, 256'(y), 256'(0));
        check({tag, " g_idx"}, 256'(g_idx), 256'(0));
        check({tag, " round"}, 256'(round), 256'(0));
        check({tag, " last"}, 256'(last), 256'(0));
    endtask

    // Literal values worked out by hand from SIGMA with word k = k.
    task automatic dir_checks(input int r, input int g);
`ifdef BLAKE2_SCHED_PAR4_EN
        if (r == 0 && g == 0) begin
            check("beat0 x", 256'(x), pack4(0, 2, 4, 6));
            check("beat0 y", 256'(y), pack4(1, 3, 5, 7));
        end
        if (r == 1 && g == 4) begin
            check("beat3 x", 256'(x), pack4(1, 0, 11, 5));
            check("beat3 y", 256'(y), pack4(12, 2, 7, 3));
        end
        if (r == 9 && g == 4) check("beat19 last", 256'(last), 256'(1));
`else
        if (r == 0 && g == 0) begin
            check("r0g0 x", 256'(x), 256'(0));
            check("r0g0 y", 256'(y), 256'(1));
        end
        if (r == 0 && g == 7) begin
            check("r0g7 x", 256'(x), 256'(14));
            check("r0g7 y", 256'(y), 256'(15));
        end
        if (r == 1 && g == 0) begin
            check("r1g0 x", 256'(x), 256'(14));
            check("r1g0 y", 256'(y), 256'(10));
        end
        if (r == 10 && g == 0) begin
            check("r10g0 x", 256'(x), 256'(0));
            check("r10g0 y", 256'(y), 256'(1));
        end
        if (r == 11 && g == 7) begin
            check("r11g7 x", 256'(x), 256'(5));
            check("r11g7 y", 256'(y), 256'(3));
            check("r11g7 last", 256'(last), 256'(1));
        end
`endif
    endtask

    task automatic load_block(input int base);
        check("load m_ready", 256'(m_ready), 256'(1));
        m_valid = 1'b1;
        for (int k = 0; k < 16; k++) m[k*W +: W] = W'(base + k);
        step();
        m_valid = 1'b0;
    endtask

    task automatic run_block(input int base, input bit stall_en, input bit ignore_en,
                             input int abort_r, input int abort_g);
        int er = 0;
        int eg = 0;
        int xfers = 0;
        int stalls = 0;
        int cyc = 0;
        bit done = 1'b0;
        while (!done && cyc < 400) begin
            cyc++;
            check("valid", 256'(valid), 256'(1));
            check("m_ready busy", 256'(m_ready), 256'(0));
            check("round", 256'(round), 256'(er));
            check("g_idx", 256'(g_idx), 256'(eg));
            check("x", 256'(x), exp_word(er, eg, base, 0));
            check("y", 256'(y), exp_word(er, eg, base, 1));
            check("last", 256'(last), 256'(er == R - 1 && eg == GLAST));
            if (base == 0) dir_checks(er, eg);
            ready   = 1'b1;
            m_valid = 1'b0;
            if (er == abort_r && eg == abort_g) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_idle("after rst");
                return;
            end
            if (stall_en && er == 2 && eg == STALL_G && stalls < 5) begin
                ready = 1'b0;
                stalls++;
            end
            if (ignore_en && er == 4 && eg == 0) begin
                m_valid = 1'b1;
                for (int k = 0; k < 16; k++) m[k*W +: W] = W'(base + 100 + k);
            end
            if (ready) begin
                xfers++;
                if (er == R - 1 && eg == GLAST) begin
                    done = 1'b1;
                end else if (eg == GLAST) begin
                    eg = 0;
                    er++;
                end else begin
                    eg += GSTEP;
                end
            end
            step();
        end
        m_valid = 1'b0;
        check("block done in budget", 256'(done), 256'(1));
        check("transfers", 256'(xfers), 256'(8 * R / GSTEP));
        if (stall_en) check("stall cycles", 256'(stalls), 256'(5));
        check_idle("end of block");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        m_valid  = 1'b0;
        ready    = 1'b0;
        m        = '0;
        repeat (3) step();
        rst = 1'b0;
        check_idle("reset");

        load_block(0);
        run_block(0, 1'b1, 1'b1, -1, -1);

        load_block(32);
        run_block(32, 1'b0, 1'b0, 5, ABORT_G);

        load_block(0);
        run_block(0, 1'b0, 1'b0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
